// File: rtl/opsum_pkg.sv
// Shared opsum constants and the GLB writer state encoding.
package opsum_pkg;

  localparam int OPSUM_W       = 16;
  localparam int ROW_NUM       = 32;
  localparam int WORDS_PER_ROW = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } wr_state_e;

endpackage

// File: rtl/opsum_skid_fifo.sv
// 2-entry FIFO between the opsum handshake and the GLB write port.
// Push and pop in the same cycle are legal at any count, including full.
module opsum_skid_fifo #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              full,
  output logic              empty
);

  logic [1:0][DATA_W-1:0] mem;
  logic                   wr_ptr, rd_ptr;
  logic [1:0]             count;
  logic                   push_ok, pop_ok;

  assign full    = (count == 2'd2);
  assign empty   = (count == 2'd0);
  // When full, a same-cycle pop frees the head slot, which is exactly where wr_ptr points.
  assign push_ok = push && (!full || pop);
  assign pop_ok  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // Storage, pointers and occupancy.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem    <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop_ok) rd_ptr <= ~rd_ptr;
      count <= count + 2'(push_ok) - 2'(pop_ok);
    end
  end

endmodule

// File: rtl/opsum_glb_writer.sv
// Drains packed opsum words from the handshake into the GLB, generating
// row-major byte addresses (two words per PE row, upper pair first).
module opsum_glb_writer
  import opsum_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 2 * OPSUM_W,
  parameter int CNT_W  = 7
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  word_num,
  input  logic [15:0]       row_pitch,
  input  logic              valid_op,
  output logic              ready_op,
  input  logic [DATA_W-1:0] opsum_in,
  output logic              glb_en,
  output logic [3:0]        glb_web,
  output logic [ADDR_W-1:0] glb_addr,
  output logic [DATA_W-1:0] glb_wdata,
  input  logic              glb_ready,
  output logic              busy,
  output logic              done
);

  wr_state_e         state, next_state;
  logic [CNT_W-1:0]  cfg_words;
  logic [15:0]       cfg_pitch;
  logic [CNT_W-1:0]  acc_cnt, wr_cnt;
  logic [ADDR_W-1:0] row_addr;
  logic              half;
  logic              buf_full, buf_empty;
  logic              push, pop;

  // Accept only when there is room and the tile still owes words.
  assign ready_op = (state == BUSY) && !buf_full && (acc_cnt < cfg_words);
  assign push     = valid_op && ready_op;
  assign glb_en   = !buf_empty;
  assign pop      = glb_en && glb_ready;
  assign glb_web  = glb_en ? 4'b0000 : 4'hF;
  assign glb_addr = row_addr + (half ? ADDR_W'(4) : ADDR_W'(0));

  opsum_skid_fifo #(.DATA_W(DATA_W)) u_buf (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (opsum_in),
    .dout  (glb_wdata),
    .full  (buf_full),
    .empty (buf_empty)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // Next-state and status outputs.
  always_comb begin
    next_state = state;
    busy       = (state != IDLE);
    done       = 1'b0;
    case (state)
      IDLE: if (start) next_state = (word_num == '0) ? DONE : BUSY;
      BUSY: if (wr_cnt == cfg_words) next_state = DONE;
      DONE: begin
        done       = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Tile config latch, counters and address walk.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cfg_words <= '0;
      cfg_pitch <= '0;
      acc_cnt   <= '0;
      wr_cnt    <= '0;
      row_addr  <= '0;
      half      <= 1'b0;
    end else if (state == IDLE) begin
      if (start) begin
        cfg_words <= word_num;
        cfg_pitch <= row_pitch;
        acc_cnt   <= '0;
        wr_cnt    <= '0;
        row_addr  <= base_addr;
        half      <= 1'b0;
      end
    end else begin
      if (push) acc_cnt <= acc_cnt + 1'b1;
      if (pop) begin
        wr_cnt <= wr_cnt + 1'b1;
        half   <= ~half;
        // Lower pair written: step to the next row's first word.
        if (half) row_addr <= row_addr + {{(ADDR_W-16){1'b0}}, cfg_pitch};
      end
    end
  end

endmodule

// File: tb/tb_opsum_glb_writer.sv
// Directed bench for opsum_glb_writer: tile runs with expected GLB traffic.
module tb_opsum_glb_writer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] base_addr;
  logic [6:0]  word_num;
  logic [15:0] row_pitch;
  logic        valid_op;
  logic        ready_op;
  logic [31:0] opsum_in;
  logic        glb_en;
  logic [3:0]  glb_web;
  logic [31:0] glb_addr;
  logic [31:0] glb_wdata;
  logic        glb_ready;
  logic        busy;
  logic        done;

  opsum_glb_writer dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .base_addr (base_addr),
    .word_num  (word_num),
    .row_pitch (row_pitch),
    .valid_op  (valid_op),
    .ready_op  (ready_op),
    .opsum_in  (opsum_in),
    .glb_en    (glb_en),
    .glb_web   (glb_web),
    .glb_addr  (glb_addr),
    .glb_wdata (glb_wdata),
    .glb_ready (glb_ready),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mkdata(input int t, input int i);
    return {8'(t), 8'hC0, 16'(i)};
  endfunction

  // Per-run observations.
  logic [31:0] wa[$];
  logic [31:0] wd[$];
  logic        c_rdy[256];
  logic        c_en[256];
  logic        c_busy[256];
  logic [31:0] c_addr[256];
  logic [31:0] c_data[256];
  int acc, rdy_seen, en_seen, done_cnt, done_cyc, web_bad;

  // Runs one tile. Inputs change on the falling edge; outputs are sampled
  // 1ns later. Config inputs are scrambled after cycle 0 so only the value
  // latched at start can produce the expected traffic.
  task automatic run_tile(input int t, input logic [31:0] b, input int n,
                          input logic [15:0] p, input int stlo, input int sthi,
                          input int start2, input int abort_wr, input int maxc);
    bit fin = 0;
    wa.delete(); wd.delete();
    acc = 0; rdy_seen = 0; en_seen = 0; done_cnt = 0; done_cyc = -1; web_bad = 0;
    for (int cyc = 0; cyc < maxc && !fin; cyc++) begin
      @(negedge clk);
      start     = (cyc == 0) || (cyc == start2);
      base_addr = (cyc == 0) ? b : 32'hDEAD_0000;
      word_num  = (cyc == 0) ? 7'(n) : 7'd3;
      row_pitch = (cyc == 0) ? p : 16'h0004;
      glb_ready = !(cyc >= stlo && cyc < sthi);
      valid_op  = 1'b1;
      opsum_in  = mkdata(t, acc);
      #1;
      c_rdy[cyc] = ready_op; c_en[cyc] = glb_en; c_busy[cyc] = busy;
      c_addr[cyc] = glb_addr; c_data[cyc] = glb_wdata;
      if (ready_op) rdy_seen++;
      if (glb_en) en_seen++;
      if (glb_en && glb_web !== 4'b0000) web_bad++;
      if (!glb_en && glb_web !== 4'hF) web_bad++;
      if (done) begin done_cnt++; done_cyc = cyc; end
      if (valid_op && ready_op) acc++;
      if (glb_en && glb_ready) begin wa.push_back(glb_addr); wd.push_back(glb_wdata); end
      if (done_cyc >= 0 && cyc >= done_cyc + 2) fin = 1;
      if (abort_wr > 0 && wa.size() == abort_wr) fin = 1;
    end
    start = 1'b0;
    if (abort_wr == 0) chk($sformatf("t%0d_done_seen", t), 32'(done_cyc >= 0), 32'd1);
  endtask

  task automatic check_writes(input int t, input logic [31:0] b, input int n, input logic [15:0] p);
    chk($sformatf("t%0d_nwrites", t), 32'(wa.size()), 32'(n));
    chk($sformatf("t%0d_naccepts", t), 32'(acc), 32'(n));
    chk($sformatf("t%0d_web", t), 32'(web_bad), 32'd0);
    for (int i = 0; i < n && i < wa.size(); i++) begin
      chk($sformatf("t%0d_addr%0d", t, i), wa[i], b + 32'(i / 2) * {16'h0, p} + 32'((i % 2) * 4));
      chk($sformatf("t%0d_data%0d", t, i), wd[i], mkdata(t, i));
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; base_addr = '0; word_num = '0; row_pitch = '0;
    valid_op = 1'b0; opsum_in = '0; glb_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_ready_op", 32'(ready_op), 32'd0);
    chk("rst_glb_en", 32'(glb_en), 32'd0);
    chk("rst_glb_web", 32'(glb_web), 32'hF);
    chk("rst_glb_addr", glb_addr, 32'd0);
    chk("rst_glb_wdata", glb_wdata, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    @(negedge clk) reset = 1'b0;

    // Basic 2-row tile, done at cycle 7, idle at 8.
    run_tile(1, 32'h1000, 4, 16'h40, -1, -1, -1, 0, 40);
    check_writes(1, 32'h1000, 4, 16'h40);
    chk("t1_addrs", wa.size() == 4 ? wa[2] : 32'hX, 32'h1040);
    chk("t1_done_once", 32'(done_cnt), 32'd1);
    chk("t1_done_cyc", 32'(done_cyc), 32'd7);
    chk("t1_busy_in_done", 32'(c_busy[7]), 32'd1);
    chk("t1_busy_after", 32'(c_busy[8]), 32'd0);
    chk("t1_ready_limit", 32'(c_rdy[5]), 32'd0);

    // Backpressure: GLB stalls cycles 3..7, right after the first write.
    run_tile(2, 32'h1000, 4, 16'h40, 3, 8, -1, 0, 60);
    check_writes(2, 32'h1000, 4, 16'h40);
    chk("t2_rdy_c3", 32'(c_rdy[3]), 32'd1);
    chk("t2_rdy_c5", 32'(c_rdy[5]), 32'd0);
    chk("t2_rdy_total", 32'(rdy_seen), 32'd4);
    chk("t2_addr_c3", c_addr[3], 32'h1004);
    chk("t2_addr_c7", c_addr[7], 32'h1004);
    chk("t2_data_c7", c_data[7], mkdata(2, 1));
    chk("t2_en_c7", 32'(c_en[7]), 32'd1);
    chk("t2_done_once", 32'(done_cnt), 32'd1);

    // Zero tile: straight to DONE, no traffic.
    run_tile(3, 32'h5000, 0, 16'h10, -1, -1, -1, 0, 20);
    chk("t3_done_cyc", 32'(done_cyc), 32'd1);
    chk("t3_done_once", 32'(done_cnt), 32'd1);
    chk("t3_en_seen", 32'(en_seen), 32'd0);
    chk("t3_rdy_seen", 32'(rdy_seen), 32'd0);
    chk("t3_busy_after", 32'(c_busy[2]), 32'd0);

    // Full 64-word tile wrapping past 2^32.
    run_tile(4, 32'hFFFF_FFF8, 64, 16'h8, -1, -1, -1, 0, 200);
    check_writes(4, 32'hFFFF_FFF8, 64, 16'h8);
    chk("t4_wrap_addr2", wa.size() > 2 ? wa[2] : 32'hX, 32'h0000_0000);
    chk("t4_rdy_total", 32'(rdy_seen), 32'd64);
    chk("t4_done_once", 32'(done_cnt), 32'd1);

    // Start re-pulsed in BUSY with scrambled config must be ignored.
    run_tile(5, 32'h3000, 6, 16'h20, -1, -1, 3, 0, 60);
    check_writes(5, 32'h3000, 6, 16'h20);
    chk("t5_done_once", 32'(done_cnt), 32'd1);

    // Reset after 3 of 6 writes: outputs clear at once, no done.
    run_tile(6, 32'h4000, 6, 16'h20, -1, -1, -1, 3, 60);
    chk("t6_writes_pre", 32'(wa.size()), 32'd3);
    @(posedge clk); #1;
    reset = 1'b1; valid_op = 1'b0; #1;
    chk("t6_rst_ready_op", 32'(ready_op), 32'd0);
    chk("t6_rst_glb_en", 32'(glb_en), 32'd0);
    chk("t6_rst_glb_web", 32'(glb_web), 32'hF);
    chk("t6_rst_glb_addr", glb_addr, 32'd0);
    chk("t6_rst_glb_wdata", glb_wdata, 32'd0);
    chk("t6_rst_busy", 32'(busy), 32'd0);
    begin
      int dseen = 0;
      for (int i = 0; i < 4; i++) begin
        @(negedge clk);
        if (i == 2) reset = 1'b0;
        #1;
        if (done) dseen++;
      end
      chk("t6_no_done", 32'(dseen + done_cnt), 32'd0);
    end

    // Clean tile after the abort.
    run_tile(7, 32'h2000, 2, 16'h10, -1, -1, -1, 0, 30);
    check_writes(7, 32'h2000, 2, 16'h10);
    chk("t7_done_once", 32'(done_cnt), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
